fpu_addsub: RTL and testbench

FPU_ADDSUB -- requirements
Module: fpu_addsub

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fpu_lzc.sv | 21 ++
 rtl/fpu_addsub.sv | 253 +++++++++++++++++++++++++
 tb/tb_fpu_addsub.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared flag indices, qNaN generator and derived widths for the FP add/sub pipeline
package fpu_pkg;

  // Bit positions inside the 4-bit {NV,OF,UF,NX} flag vector
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NV = 3;

  // Significand width including the implicit bit
  function automatic int sig_w(input int man_w);
    return man_w + 1;
  endfunction

  // Working mantissa width: significand plus guard, round and sticky
  function automatic int ext_w(input int man_w);
    return man_w + 4;
  endfunction

  // Width of a count that can hold 0..width inclusive
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Canonical quiet NaN in the low 1+exp_w+man_w bits: sign 0, exponent all ones, fraction MSB only
  function automatic logic [127:0] qnan_word(input int exp_w, input int man_w);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - leading-zero counter, returns W for an all-zero input
module fpu_lzc
  import fpu_pkg::*;
#(
  parameter int W = 27
) (
  input  logic [W-1:0]           i_data,
  output logic [cnt_w(W)-1:0]    o_count
);

  localparam int CNT_W = cnt_w(W);

  // Scan upward so the highest set bit writes last and wins
  always_comb begin
    o_count = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_count = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub.sv
// rtl/fpu_addsub.sv - three-stage pipelined IEEE-754 adder/subtractor, round-to-nearest-even
module fpu_addsub
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SIG  = sig_w(MAN_W);
  localparam int E    = ext_w(MAN_W);
  localparam int LZ_W = cnt_w(E);
  localparam int XW   = EXP_W + 2;
  localparam logic [W-1:0]  QNAN    = W'(qnan_word(EXP_W, MAN_W));
  localparam logic [XW-1:0] EXP_INF = XW'((1 << EXP_W) - 1);

  // ---------------- pipeline control ----------------
  logic w_adv;
  logic r_s1_valid, r_s2_valid, r_out_valid;

  assign w_adv     = !(r_out_valid && !out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;

  // ---------------- S1: unpack, specials, compare, align ----------------
  logic [W-1:0]     w_b_eff;
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;

  assign w_b_eff = {b[W-1] ^ op_sub, b[W-2:0]};
  assign {w_sa, w_ea, w_fa} = a;
  assign {w_sb, w_eb, w_fb} = w_b_eff;
  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];
  assign w_a_inf  = (&w_ea) && !(|w_fa);
  assign w_b_inf  = (&w_eb) && !(|w_fb);

  logic         w_spec;
  logic [W-1:0] w_spec_res;
  logic [3:0]   w_spec_flg;

  // NaN and infinity operands bypass the arithmetic path entirely
  always_comb begin
    w_spec     = 1'b0;
    w_spec_res = '0;
    w_spec_flg = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec              = 1'b1;
      w_spec_res          = QNAN;
      w_spec_flg[FLAG_NV] = w_a_snan || w_b_snan;
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      w_spec              = 1'b1;
      w_spec_res          = QNAN;
      w_spec_flg[FLAG_NV] = 1'b1;
    end else if (w_a_inf) begin
      w_spec     = 1'b1;
      w_spec_res = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec     = 1'b1;
      w_spec_res = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic             w_a_ge, w_sl;
  logic [EXP_W-1:0] w_xa, w_xb, w_xl, w_xs, w_d;
  logic [SIG-1:0]   w_ma, w_mb;
  logic [E-1:0]     w_ml, w_ms_raw, w_ms_shift, w_lost, w_ms_al;
  logic [LZ_W-1:0]  w_sh;

  // Subnormals behave as exponent 1 with a zero implicit bit
  assign w_a_ge = (a[W-2:0] >= w_b_eff[W-2:0]);
  assign w_xa   = (w_ea == '0) ? EXP_W'(1) : w_ea;
  assign w_xb   = (w_eb == '0) ? EXP_W'(1) : w_eb;
  assign w_ma   = {|w_ea, w_fa};
  assign w_mb   = {|w_eb, w_fb};

  // Order operands by magnitude and right-align the smaller, folding lost bits into sticky
  always_comb begin
    w_sl     = w_a_ge ? w_sa : w_sb;
    w_xl     = w_a_ge ? w_xa : w_xb;
    w_xs     = w_a_ge ? w_xb : w_xa;
    w_ml     = w_a_ge ? {w_ma, 3'b000} : {w_mb, 3'b000};
    w_ms_raw = w_a_ge ? {w_mb, 3'b000} : {w_ma, 3'b000};
    w_d      = w_xl - w_xs;
    if (int'(w_d) > MAN_W + 3) w_sh = LZ_W'(MAN_W + 3);
    else                       w_sh = LZ_W'(w_d);
    w_ms_shift = w_ms_raw >> w_sh;
    w_lost     = w_ms_raw & ~({E{1'b1}} << w_sh);
    w_ms_al    = {w_ms_shift[E-1:1], w_ms_shift[0] | (|w_lost)};
  end

  logic             r_s1_spec, r_s1_sign, r_s1_sub;
  logic [W-1:0]     r_s1_spec_res;
  logic [3:0]       r_s1_spec_flg;
  logic [EXP_W-1:0] r_s1_exp;
  logic [E-1:0]     r_s1_ml, r_s1_ms;

  // Stage-1 valid bit, cleared at once by reset so in-flight work vanishes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_s1_valid <= 1'b0;
    else if (w_adv) r_s1_valid <= in_valid;
  end

  // Stage-1 datapath capture; contents are don't-care while the valid bit is low
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s1_spec     <= w_spec;
      r_s1_spec_res <= w_spec_res;
      r_s1_spec_flg <= w_spec_flg;
      r_s1_sign     <= w_sl;
      r_s1_sub      <= w_sa ^ w_sb;
      r_s1_exp      <= w_xl;
      r_s1_ml       <= w_ml;
      r_s1_ms       <= w_ms_al;
    end
  end

  // ---------------- S2: magnitude add/sub ----------------
  logic [E:0] w_sum;
  logic       w_sign2;

  assign w_sum   = r_s1_sub ? ({1'b0, r_s1_ml} - {1'b0, r_s1_ms})
                            : ({1'b0, r_s1_ml} + {1'b0, r_s1_ms});
  assign w_sign2 = (r_s1_sub && (w_sum == '0)) ? 1'b0 : r_s1_sign;

  logic             r_s2_spec, r_s2_sign;
  logic [W-1:0]     r_s2_spec_res;
  logic [3:0]       r_s2_spec_flg;
  logic [EXP_W-1:0] r_s2_exp;
  logic [E:0]       r_s2_sum;

  // Stage-2 valid bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_s2_valid <= 1'b0;
    else if (w_adv) r_s2_valid <= r_s1_valid;
  end

  // Stage-2 datapath capture
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_s2_spec     <= r_s1_spec;
      r_s2_spec_res <= r_s1_spec_res;
      r_s2_spec_flg <= r_s1_spec_flg;
      r_s2_sign     <= w_sign2;
      r_s2_exp      <= r_s1_exp;
      r_s2_sum      <= w_sum;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZ_W-1:0] w_lz;
  logic [E-1:0]    w_norm;
  logic [XW-1:0]   w_en, w_nsh, w_lim;

  fpu_lzc #(.W(E)) u_lzc (
    .i_data  (r_s2_sum[E-1:0]),
    .o_count (w_lz)
  );

  // Carry shifts right by one; otherwise shift left but never below exponent 1 (gradual underflow)
  always_comb begin
    w_norm = '0;
    w_en   = '0;
    w_nsh  = '0;
    w_lim  = XW'(r_s2_exp) - XW'(1);
    if (r_s2_sum[E]) begin
      w_norm = {r_s2_sum[E:2], r_s2_sum[1] | r_s2_sum[0]};
      w_en   = XW'(r_s2_exp) + XW'(1);
    end else begin
      w_nsh  = (XW'(w_lz) > w_lim) ? w_lim : XW'(w_lz);
      w_norm = r_s2_sum[E-1:0] << w_nsh;
      w_en   = XW'(r_s2_exp) - w_nsh;
    end
  end

  logic             w_nx, w_rup;
  logic [SIG:0]     w_mr;
  logic [XW-1:0]    w_ef;
  logic [MAN_W-1:0] w_frac;
  logic [W-1:0]     w_res;
  logic [3:0]       w_flg;

  assign w_nx  = |w_norm[2:0];
  assign w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mr  = {1'b0, w_norm[E-1:3]} + (SIG+1)'(w_rup);

  // Round-up carry bumps the exponent; a clear implicit bit encodes as subnormal/zero
  always_comb begin
    w_ef   = '0;
    w_frac = '0;
    w_flg  = '0;
    if (w_mr[SIG]) begin
      w_ef   = w_en + XW'(1);
      w_frac = w_mr[MAN_W:1];
    end else if (w_mr[MAN_W]) begin
      w_ef   = w_en;
      w_frac = w_mr[MAN_W-1:0];
    end else begin
      w_ef   = '0;
      w_frac = w_mr[MAN_W-1:0];
    end
    w_res = {r_s2_sign, w_ef[EXP_W-1:0], w_frac};
    if (r_s2_spec) begin
      w_res = r_s2_spec_res;
      w_flg = r_s2_spec_flg;
    end else if (w_ef >= EXP_INF) begin
      w_res          = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flg[FLAG_OF] = 1'b1;
      w_flg[FLAG_NX] = 1'b1;
    end else begin
      w_flg[FLAG_NX] = w_nx;
      w_flg[FLAG_UF] = (w_ef == '0) && w_nx;
    end
  end

  logic [W-1:0] r_result;
  logic [3:0]   r_flags;

  assign result = r_result;
  assign flags  = r_flags;

  // Output register holds steady while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_result <= w_res;
        r_flags  <= w_flg;
      end
    end
  end

endmodule

// File: tb/tb_fpu_addsub.sv
// tb/tb_fpu_addsub.sv - directed self-checking bench for fpu_addsub (single and half precision)
module tb_fpu_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic [3:0]  h_flags;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_addsub dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  fpu_addsub #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .op_sub(h_op_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .flags(h_flags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input logic [31:0] er, input logic [3:0] ef);
    int lat;
    a = ta; b = tb_v; op_sub = ts; in_valid = 1'b1;
    #1;
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, 32'd3);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, {28'b0, flags}, {28'b0, ef});
    step();
  endtask

  task automatic run_half(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [15:0] er, input logic [3:0] ef);
    int lat;
    h_a = ta; h_b = tb_v; h_op_sub = 1'b0; h_in_valid = 1'b1;
    step();
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, 32'd3);
    chk({tag, " result"}, {16'b0, h_result}, {16'b0, er});
    chk({tag, " flags"}, {28'b0, h_flags}, {28'b0, ef});
    step();
  endtask

  logic [31:0] va [6];
  logic [31:0] ve [6];
  logic [31:0] got_r [$];
  logic [3:0]  got_f [$];
  int          sent;
  int          seen;

  initial begin
    va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    ve = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

    rst = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_op_sub = 1'b0; h_out_ready = 1'b1;
    step();
    step();
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset flags", {28'b0, flags}, 32'd0);
    rst = 1'b1;
    #1;
    chk("post-reset in_ready", {31'b0, in_ready}, 32'd1);
    step();

    run_op("1+1",        32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0);
    run_op("inf-inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8);
    run_op("1-1",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0);
    run_op("tie even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1);
    run_op("tie odd",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1);
    run_op("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5);
    run_op("subnormal",  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'h0);
    run_op("1-2",        32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0);
    run_op("inf+1",      32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0);
    run_op("-inf+-inf",  32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'h0);
    run_op("snan",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8);
    run_op("qnan",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0);
    run_op("-0+-0",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
    run_op("-0-+0",      32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0);
    run_op("1-ulp/2",    32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'h0);
    run_op("1-tiny",     32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 4'h1);

    sent = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      if (sent < 6) begin
        in_valid = 1'b1; a = va[sent]; b = 32'h3F800000; op_sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 4 && c <= 8) chk($sformatf("stall in_ready c%0d", c), {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        got_r.push_back(result);
        got_f.push_back(flags);
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall count", got_r.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stall result %0d", i), (i < got_r.size()) ? got_r[i] : 32'hDEADBEEF, ve[i]);
      chk($sformatf("stall flags %0d", i), (i < got_f.size()) ? {28'b0, got_f[i]} : 32'hDEADBEEF, 32'd0);
    end

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = va[i]; b = 32'h3F800000; op_sub = 1'b0;
      h_in_valid = 1'b1; h_a = 16'h3C00; h_b = 16'h3C00;
      step();
    end
    in_valid = 1'b0;
    h_in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst flags", {28'b0, flags}, 32'd0);
    chk("rst half out_valid", {31'b0, h_out_valid}, 32'd0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("release in_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid || h_out_valid) seen++;
    end
    chk("no stale output", seen, 32'd0);

    run_op("recover 2+1", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'h0);
    run_half("half 1+1", 16'h3C00, 16'h3C00, 16'h4000, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
